// File: rtl/nano_cpu_pkg.sv
// rtl/nano_cpu_pkg.sv - shared types and widths for the nano_cpu core
// Purpose: opcode and FSM state encodings plus the fixed datapath widths.
// Ports: none (package).
package nano_cpu_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int NREGS  = 16;

  typedef enum logic [3:0] {
    OP_LD   = 4'h0,
    OP_ST   = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_JMP  = 4'h4,
    OP_JMPZ = 4'h5,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/nano_regfile.sv
// rtl/nano_regfile.sv - 16 x 16-bit register file for nano_cpu
// Purpose: two combinational read ports, one synchronous write port,
//          asynchronous active-low clear of every register.
// Ports: clk_i, rst_ni, we_i/waddr_i/wdata_i (write),
//        raddr_a_i/rdata_a_o and raddr_b_i/rdata_b_o (reads).
module nano_regfile
  import nano_cpu_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     we_i,
  input  logic [$clog2(NREGS)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(NREGS)-1:0] raddr_a_i,
  output logic [DATA_W-1:0]        rdata_a_o,
  input  logic [$clog2(NREGS)-1:0] raddr_b_i,
  output logic [DATA_W-1:0]        rdata_b_o
);

  logic [DATA_W-1:0] regs_q [NREGS];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/nano_cpu.sv
// rtl/nano_cpu.sv - multicycle 16-bit CPU core of the nano system
// Purpose: FETCH/EXEC control FSM, PC, IR and ALU around nano_regfile.
// Ports: ck (clock), rst (async active-low reset), address/dataW/ce/we
//        (memory request, combinational), dataR (combinational read data).
module nano_cpu
  import nano_cpu_pkg::*;
(
  input  logic              ck,
  input  logic              rst,
  output logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] dataR,
  output logic [DATA_W-1:0] dataW,
  output logic              ce,
  output logic              we
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  logic [3:0]        op;
  logic [ADDR_W-1:0] op_addr;
  logic [3:0]        rt;
  logic [3:0]        ra_a;
  logic [DATA_W-1:0] rd_a, rd_b;
  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;

  assign op      = ir_q[15:12];
  assign op_addr = ir_q[11:4];
  assign rt      = ir_q[3:0];
  // Port A serves rs1 for ALU ops and rt for ST/JMPZ; port B is always rs2.
  assign ra_a    = (op == OP_ADD || op == OP_SUB) ? ir_q[11:8] : rt;

  nano_regfile u_rf (
    .clk_i     (ck),
    .rst_ni    (rst),
    .we_i      (rf_we),
    .waddr_i   (rt),
    .wdata_i   (rf_wdata),
    .raddr_a_i (ra_a),
    .rdata_a_o (rd_a),
    .raddr_b_i (ir_q[7:4]),
    .rdata_b_o (rd_b)
  );

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    address  = '0;
    dataW    = '0;
    ce       = 1'b0;
    we       = 1'b0;
    rf_we    = 1'b0;
    rf_wdata = '0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        address = pc_q;
        ce      = 1'b1;
        ir_d    = dataR;
        pc_d    = pc_q + 8'd1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (op)
          OP_LD: begin
            address  = op_addr;
            ce       = 1'b1;
            rf_we    = 1'b1;
            rf_wdata = dataR;
          end
          OP_ST: begin
            address = op_addr;
            ce      = 1'b1;
            we      = 1'b1;
            dataW   = rd_a;
          end
          OP_ADD: begin
            rf_we    = 1'b1;
            rf_wdata = rd_a + rd_b;
          end
          OP_SUB: begin
            rf_we    = 1'b1;
            rf_wdata = rd_a - rd_b;
          end
          OP_JMP:  pc_d = op_addr;
          OP_JMPZ: if (rd_a == '0) pc_d = op_addr;
          OP_HALT: state_d = S_HALT;
          default: ;
        endcase
      end
      S_HALT: address = pc_q;
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_nano_cpu.sv
// tb/tb_nano_cpu.sv - self-checking bench for nano_cpu with an ISA-level model
module tb_nano_cpu;

  logic        ck = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  address;
  logic [15:0] dataR;
  logic [15:0] dataW;
  logic        ce;
  logic        we;

  logic [15:0] mem [256];

  int n_chk = 0;
  int n_err = 0;
  int we_seen;

  typedef struct {
    logic [7:0]  addr;
    logic        ce;
    logic        we;
    logic [15:0] dw;
    logic        chk_addr;
  } bus_t;

  bus_t        exp_q[$];
  logic [15:0] m_mem [256];
  logic [15:0] m_r   [16];

  always #5 ck = ~ck;

  nano_cpu dut (
    .ck      (ck),
    .rst     (rst),
    .address (address),
    .dataR   (dataR),
    .dataW   (dataW),
    .ce      (ce),
    .we      (we)
  );

  assign dataR = mem[address];

  always @(posedge ck) if (we) mem[address] <= dataW;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs the program in m_mem instruction by instruction and lists the
  // bus activity each clock cycle should show, starting with the idle cycle.
  task automatic build_model();
    logic [7:0]  pc;
    logic [15:0] ir;
    logic [7:0]  a;
    logic [3:0]  rt;
    bus_t        b;
    exp_q.delete();
    for (int i = 0; i < 256; i++) m_mem[i] = mem[i];
    for (int i = 0; i < 16; i++) m_r[i] = 16'h0;
    b = '{8'h00, 1'b0, 1'b0, 16'h0, 1'b1};
    exp_q.push_back(b);
    pc = 8'h00;
    for (int step = 0; step < 100; step++) begin
      ir = m_mem[pc];
      a  = ir[11:4];
      rt = ir[3:0];
      b = '{pc, 1'b1, 1'b0, 16'h0, 1'b1};
      exp_q.push_back(b);
      pc = pc + 8'd1;
      b = '{8'h00, 1'b0, 1'b0, 16'h0, 1'b0};
      case (ir[15:12])
        4'h0: begin b = '{a, 1'b1, 1'b0, 16'h0, 1'b1}; m_r[rt] = m_mem[a]; end
        4'h1: begin b = '{a, 1'b1, 1'b1, m_r[rt], 1'b1}; m_mem[a] = m_r[rt]; end
        4'h2: m_r[rt] = m_r[ir[11:8]] + m_r[ir[7:4]];
        4'h3: m_r[rt] = m_r[ir[11:8]] - m_r[ir[7:4]];
        4'h4: pc = a;
        4'h5: if (m_r[rt] == 16'h0) pc = a;
        default: ;
      endcase
      exp_q.push_back(b);
      if (ir[15:12] == 4'hF) begin
        for (int k = 0; k < 4; k++) begin
          b = '{pc, 1'b0, 1'b0, 16'h0, 1'b1};
          exp_q.push_back(b);
        end
        break;
      end
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[30] = 16'h1111;
    mem[31] = 16'h2222;
  endtask

  task automatic start();
    rst = 1'b0;
    build_model();
    @(posedge ck);
    #1;
    chk("reset_outs", {address, dataW, ce, we}, 26'h0);
    rst = 1'b1;
    we_seen = 0;
  endtask

  // Compares n cycles of bus activity (n < 0: all remaining) against the model.
  task automatic follow(input int n);
    bus_t b;
    int   cnt = 0;
    while (exp_q.size() > 0 && (n < 0 || cnt < n)) begin
      b = exp_q.pop_front();
      @(negedge ck);
      chk("ce", {31'h0, ce}, {31'h0, b.ce});
      chk("we", {31'h0, we}, {31'h0, b.we});
      chk("dataW", {16'h0, dataW}, {16'h0, b.dw});
      if (b.chk_addr) chk("address", {24'h0, address}, {24'h0, b.addr});
      if (we) we_seen++;
      cnt++;
    end
  endtask

  task automatic check_mem_image();
    int diffs = 0;
    @(posedge ck);
    #1;
    for (int i = 0; i < 256; i++) if (mem[i] !== m_mem[i]) diffs++;
    chk("mem_image_diffs", diffs, 0);
  endtask

  initial begin
    // Load and halt
    clear_mem();
    mem[0] = 16'h01E0; mem[1] = 16'h01F1; mem[2] = 16'hF000;
    start();
    follow(-1);
    chk("halt_addr", {24'h0, address}, 32'h03);
    chk("halt_ce_we", {30'h0, ce, we}, 32'h0);
    chk("load_no_writes", we_seen, 0);
    check_mem_image();

    // Store
    clear_mem();
    mem[0] = 16'h01E0; mem[1] = 16'h1280; mem[2] = 16'hF000;
    start();
    follow(-1);
    chk("store_we_cycles", we_seen, 1);
    check_mem_image();
    chk("store_mem40", {16'h0, mem[40]}, 32'h1111);

    // Arithmetic
    clear_mem();
    mem[0] = 16'h01E0; mem[1] = 16'h01F1; mem[2] = 16'h2012; mem[3] = 16'h1292;
    mem[4] = 16'h3013; mem[5] = 16'h12A3; mem[6] = 16'hF000;
    start();
    follow(-1);
    check_mem_image();
    chk("add_mem41", {16'h0, mem[41]}, 32'h3333);
    chk("sub_mem42", {16'h0, mem[42]}, 32'hEEEF);

    // Branch taken on a zero register
    clear_mem();
    mem[0] = 16'h5105;
    mem[16] = 16'h01E0; mem[17] = 16'h12B0; mem[18] = 16'hF000;
    start();
    follow(-1);
    check_mem_image();
    chk("jmpz_taken_mem43", {16'h0, mem[43]}, 32'h1111);
    chk("jmpz_taken_halt_pc", {24'h0, address}, 32'h13);

    // Branch not taken on a non-zero register
    clear_mem();
    mem[0] = 16'h01E5; mem[1] = 16'h5105; mem[2] = 16'h12C5; mem[3] = 16'hF000;
    mem[16] = 16'hF000;
    start();
    follow(-1);
    check_mem_image();
    chk("jmpz_fall_mem44", {16'h0, mem[44]}, 32'h1111);
    chk("jmpz_fall_halt_pc", {24'h0, address}, 32'h04);

    // Reset during EXEC of a store
    clear_mem();
    mem[0] = 16'h01E0; mem[1] = 16'h1280; mem[2] = 16'hF000;
    start();
    follow(4);
    @(negedge ck);
    chk("pre_abort_we", {31'h0, we}, 32'h1);
    chk("pre_abort_addr", {24'h0, address}, 32'h28);
    rst = 1'b0;
    #1;
    chk("abort_outs", {address, dataW, ce, we}, 26'h0);
    @(posedge ck);
    #1;
    chk("abort_no_write", {16'h0, mem[40]}, 32'h0);
    start();
    follow(-1);
    check_mem_image();
    chk("restart_mem40", {16'h0, mem[40]}, 32'h1111);

    // PC wrap: 0x00 -> 0xFF -> 0x00 -> 0x01
    clear_mem();
    mem[0] = 16'h5FF1; mem[255] = 16'h01E1; mem[1] = 16'hF000;
    start();
    follow(-1);
    check_mem_image();
    chk("wrap_halt_pc", {24'h0, address}, 32'h02);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
